// File: rtl/mult_arb_pkg.sv
// rtl/mult_arb_pkg.sv - shared types and constants for the multiplier arbiter
// Purpose: FSM state type, default parameter values and width helpers used by
//          mult_arbiter and rr_pick.
// Ports:   none (package)
package mult_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LAUNCH  = 2'd1,
    ST_WAIT    = 2'd2,
    ST_DELIVER = 2'd3
  } state_t;

  localparam int N_REQ_DEFAULT       = 4;
  localparam int WIDTH_DEFAULT       = 8;
  localparam int MUL_LATENCY_DEFAULT = 10;

  // Counter must hold MUL_LATENCY-1; keep at least one bit when the latency is 1.
  function automatic int cnt_width(input int lat);
    return (lat < 2) ? 1 : $clog2(lat);
  endfunction

  // Width of a binary requester index; at least one bit.
  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int CNT_W_DEFAULT = cnt_width(MUL_LATENCY_DEFAULT);

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin selector
// Purpose: pick the first asserted request scanning from ptr upward with wrap.
// Ports:   req     - request vector
//          ptr     - index holding highest priority
//          win     - one-hot winner (zero when no request)
//          win_idx - binary index of the winner
//          any     - at least one request asserted
module rr_pick
  import mult_arb_pkg::*;
#(
  parameter int N     = N_REQ_DEFAULT,
  parameter int IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     win,
  output logic [IDX_W-1:0] win_idx,
  output logic             any
);

  // Scan from the lowest priority toward ptr so the last hit (closest to ptr) wins.
  always_comb begin
    win     = '0;
    win_idx = '0;
    any     = |req;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        win                          = '0;
        win[(int'(ptr) + k) % N]     = 1'b1;
        win_idx                      = IDX_W'((int'(ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// rtl/mult_arbiter.sv - round-robin sequencer sharing one multiplier among requesters
// Purpose: grant one requester at a time, drive the multiplier with its latched
//          operands, wait the fixed latency and return the product with an ack pulse.
// Ports:   clk, reset (async active-low)
//          req, a_in, b_in  - requester levels and packed operands
//          gnt, ack         - one-hot grant (LAUNCH..DELIVER) and one-cycle ack
//          result           - product, valid while ack is high
//          busy             - high outside IDLE
//          mul_start, mul_a, mul_b, mul_pp - multiplier interface
module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter int N_REQ       = N_REQ_DEFAULT,
  parameter int WIDTH       = WIDTH_DEFAULT,
  parameter int MUL_LATENCY = MUL_LATENCY_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] a_in,
  input  logic [N_REQ*WIDTH-1:0] b_in,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       ack,
  output logic [2*WIDTH-1:0]     result,
  output logic                   busy,
  output logic                   mul_start,
  output logic [WIDTH-1:0]       mul_a,
  output logic [WIDTH-1:0]       mul_b,
  input  logic [2*WIDTH-1:0]     mul_pp
);

  localparam int IDX_W = idx_width(N_REQ);
  localparam int CNT_W = cnt_width(MUL_LATENCY);

  state_t             r_state;
  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   r_idx;
  logic [CNT_W-1:0]   r_cnt;
  logic [N_REQ-1:0]   r_gnt;
  logic [N_REQ-1:0]   r_ack;
  logic [2*WIDTH-1:0] r_result;
  logic               r_busy;
  logic               r_mul_start;
  logic [WIDTH-1:0]   r_mul_a;
  logic [WIDTH-1:0]   r_mul_b;

  logic [N_REQ-1:0]   w_win;
  logic [IDX_W-1:0]   w_win_idx;
  logic               w_any;

  rr_pick #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req     (req),
    .ptr     (r_ptr),
    .win     (w_win),
    .win_idx (w_win_idx),
    .any     (w_any)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_gnt       <= '0;
      r_ack       <= '0;
      r_result    <= '0;
      r_busy      <= 1'b0;
      r_mul_start <= 1'b0;
      r_mul_a     <= '0;
      r_mul_b     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_mul_a     <= a_in[w_win_idx*WIDTH +: WIDTH];
            r_mul_b     <= b_in[w_win_idx*WIDTH +: WIDTH];
            r_gnt       <= w_win;
            r_idx       <= w_win_idx;
            r_busy      <= 1'b1;
            r_mul_start <= 1'b1;
            r_state     <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          r_mul_start <= 1'b0;
          r_cnt       <= CNT_W'(MUL_LATENCY - 1);
          r_state     <= ST_WAIT;
        end
        ST_WAIT: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_result <= mul_pp;
            r_ack    <= r_gnt;
            r_state  <= ST_DELIVER;
          end
        end
        ST_DELIVER: begin
          r_gnt   <= '0;
          r_ack   <= '0;
          r_busy  <= 1'b0;
          // The served requester drops to lowest priority for the next arbitration.
          r_ptr   <= (r_idx == IDX_W'(N_REQ - 1)) ? '0 : IDX_W'(r_idx + 1'b1);
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign ack       = r_ack;
  assign result    = r_result;
  assign busy      = r_busy;
  assign mul_start = r_mul_start;
  assign mul_a     = r_mul_a;
  assign mul_b     = r_mul_b;

endmodule
